// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl -- byte framing controller for a downstream 9-bit MSB-first
// parallel-to-serial shifter.
//
// A byte accepted in IDLE is held in an internal register and presented as a
// 9-bit word: {byte[7:0], tail}. The controller strobes load_enable once and
// then emits one shift_enable per bit period for the eight data bits. A ninth
// bit period covers the tail bit, after which tx_done pulses for one cycle.
//
// Frame length from the LOAD cycle to the last SEND cycle is 1 + 9*BIT_PERIOD
// clocks. A new byte can be taken at the earliest in the cycle after DONE.
//
// Build option:
//   TX_FRAME_PARITY_EN  defined   -> tail bit = even parity (XOR of the byte)
//   TX_FRAME_PARITY_EN  undefined -> tail bit = constant 1 (stop marker)
//
// Reset: n_rst is synchronous and active-high. An asserted reset aborts any
// frame in progress without a tx_done pulse, and data_valid is ignored in that
// cycle.

module tx_frame_ctrl #(
    parameter int BIT_PERIOD = 10   // clocks per transmitted bit, 2..1023
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [8:0] parallel_out,
    output logic       load_enable,
    output logic       shift_enable,
    output logic       busy,
    output logic       tx_done
);

    // Timer only has to reach BIT_PERIOD-1, so ceil(log2(BIT_PERIOD)) bits
    // suffice for every legal BIT_PERIOD.
    localparam int                 TIMER_W    = $clog2(BIT_PERIOD);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIT_PERIOD - 1);

    // Bit slots 0..7 carry data and get a shift strobe; slot 8 is the tail
    // bit, which is already in the shifter's last position and only needs
    // its bit period to elapse.
    localparam logic [3:0] TAIL_SLOT = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic [3:0]         bit_cnt_q;
    logic [3:0]         bit_cnt_d;
    logic [7:0]         byte_q;
    logic               capture;
    logic               bit_end;
    logic               tail_bit;

    // Last clock of the current bit period.
    assign bit_end = (timer_q == TIMER_LAST);

    // State, bit timer and bit counter registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from the
        // values that existed before the edge, independent of statement order.
        if (n_rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Captured byte: loaded only on an accepted handshake in IDLE, so it is
    // stable from LOAD through DONE and data_valid mid-frame has no effect.
    always_ff @(posedge clk) begin
        // NOTE: the byte register is reset too, so parallel_out is a known
        // value right after reset instead of whatever was left from before.
        if (n_rst) begin
            byte_q <= '0;
        end else if (capture) begin
            byte_q <= data_in;
        end
    end

    // Next-state, counter update and strobe decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        capture      = 1'b0;
        data_ready   = 1'b0;
        busy         = 1'b0;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        tx_done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    capture = 1'b1;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                busy        = 1'b1;
                load_enable = 1'b1;
                timer_d     = '0;
                bit_cnt_d   = '0;
                state_d     = SEND;
            end

            SEND: begin
                busy = 1'b1;
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_cnt_q == TAIL_SLOT) begin
                        // Tail bit period finished: no shift, frame ends.
                        state_d = DONE;
                    end else begin
                        // One strobe per data bit, at the end of its period.
                        shift_enable = 1'b1;
                        bit_cnt_d    = bit_cnt_q + 4'd1;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            DONE: begin
                busy    = 1'b1;
                tx_done = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef TX_FRAME_PARITY_EN
    // Even parity over the captured byte: the 9-bit word has an even number
    // of ones.
    assign tail_bit = ^byte_q;
`else
    // Constant stop marker, independent of reset and of the captured byte.
    assign tail_bit = 1'b1;
`endif

    // Word for the MSB-first shifter: data bits first, tail bit last.
    assign parallel_out = {byte_q, tail_bit};

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Self-checking bench for tx_frame_ctrl.
//
// Two instances share clock, reset and data_in: dut_a uses BIT_PERIOD=10,
// dut_b uses BIT_PERIOD=2. 'sel' routes data_valid to one of them and muxes
// that instance's outputs onto the o_* observation signals. Expected words are
// pushed to a scoreboard queue when a byte is offered and popped when the
// selected instance pulses load_enable. Strobe cycles are logged relative to
// the cycle in which data_valid was presented.

`timescale 1ns/1ps

module tb_tx_frame_ctrl;

    localparam int BP_A = 10;
    localparam int BP_B = 2;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] data_in;
    logic       dv;
    logic       sel;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    logic       a_dv, a_ready, a_le, a_se, a_busy, a_done;
    logic [8:0] a_po;
    logic       b_dv, b_ready, b_le, b_se, b_busy, b_done;
    logic [8:0] b_po;
    logic       o_ready, o_le, o_se, o_busy, o_done;
    logic [8:0] o_po;

    logic [8:0] sb_q[$];
    int         le_t[$];
    int         se_t[$];
    int         done_t[$];

    assign a_dv    = dv & ~sel;
    assign b_dv    = dv &  sel;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_le    = sel ? b_le    : a_le;
    assign o_se    = sel ? b_se    : a_se;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_po    = sel ? b_po    : a_po;

    tx_frame_ctrl #(.BIT_PERIOD(BP_A)) dut_a (
        .clk          (clk),
        .n_rst        (n_rst),
        .data_in      (data_in),
        .data_valid   (a_dv),
        .data_ready   (a_ready),
        .parallel_out (a_po),
        .load_enable  (a_le),
        .shift_enable (a_se),
        .busy         (a_busy),
        .tx_done      (a_done)
    );

    tx_frame_ctrl #(.BIT_PERIOD(BP_B)) dut_b (
        .clk          (clk),
        .n_rst        (n_rst),
        .data_in      (data_in),
        .data_valid   (b_dv),
        .data_ready   (b_ready),
        .parallel_out (b_po),
        .load_enable  (b_le),
        .shift_enable (b_se),
        .busy         (b_busy),
        .tx_done      (b_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference word for a byte: data in [8:1], tail bit in [0].
    function automatic logic [8:0] exp_word(input logic [7:0] b);
`ifdef TX_FRAME_PARITY_EN
        return {b, ^b};
`else
        return {b, 1'b1};
`endif
    endfunction

`ifdef TX_FRAME_PARITY_EN
    localparam logic [8:0] RESET_WORD = 9'h000;
`else
    localparam logic [8:0] RESET_WORD = 9'h001;
`endif

    task automatic clear_events();
        le_t.delete();
        se_t.delete();
        done_t.delete();
    endtask

    // Observe the selected instance once, at a falling edge.
    task automatic sample();
        logic [8:0] w;
        if (o_le === 1'b1) begin
            le_t.push_back(cyc);
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL load_unexpected cyc=%0d got load with word=%h, expected no load", cyc, o_po);
            end else begin
                w = sb_q.pop_front();
                if (o_po !== w) begin
                    bad++;
                    $display("FAIL load_word cyc=%0d got=%h exp=%h", cyc, o_po, w);
                end
            end
        end
        if (o_se === 1'b1) se_t.push_back(cyc);
        if (o_done === 1'b1) done_t.push_back(cyc);
        if (o_le === 1'b1 || o_se === 1'b1) begin
            total++;
            if (o_le === 1'b1 && o_se === 1'b1) begin
                bad++;
                $display("FAIL strobe_overlap cyc=%0d load=%b shift=%b exp one-hot", cyc, o_le, o_se);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
    endtask

    // Offer one byte once ready; returns the cycle data_valid was presented.
    task automatic launch(input logic [7:0] b, input logic [8:0] w, output int t0);
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_timeout cyc=%0d data_ready=%b after %0d cycles, exp 1", cyc, o_ready, n);
        end
        data_in = b;
        dv      = 1'b1;
        sb_q.push_back(w);
        t0 = cyc;
        tick();
        dv = 1'b0;
    endtask

    // Run until the next tx_done pulse (bounded), then one more cycle.
    task automatic wait_done(input int budget);
        int n0;
        int n;
        n0 = done_t.size();
        n  = 0;
        while (done_t.size() == n0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (done_t.size() == n0) begin
            bad++;
            $display("FAIL done_timeout cyc=%0d no tx_done within %0d cycles", cyc, budget);
        end
        tick();
    endtask

    // Compare logged strobe cycles of one frame against the expected offsets.
    task automatic check_timing(input string name, input int t0, input int bp);
        int got;
        got = (le_t.size() > 0) ? le_t[0] - t0 : -1;
        total++;
        if (le_t.size() != 1 || got != 1) begin
            bad++;
            $display("FAIL %s_load_time got=+%0d (count %0d) exp=+1 (count 1)", name, got, le_t.size());
        end
        total++;
        if (se_t.size() != 8) begin
            bad++;
            $display("FAIL %s_shift_count got=%0d exp=8", name, se_t.size());
        end
        for (int k = 0; k < 8 && k < se_t.size(); k++) begin
            total++;
            if (se_t[k] - t0 != 1 + bp * (k + 1)) begin
                bad++;
                $display("FAIL %s_shift_time[%0d] got=+%0d exp=+%0d", name, k, se_t[k] - t0, 1 + bp * (k + 1));
            end
        end
        got = (done_t.size() > 0) ? done_t[0] - t0 : -1;
        total++;
        if (done_t.size() != 1 || got != 2 + 9 * bp) begin
            bad++;
            $display("FAIL %s_done_time got=+%0d (count %0d) exp=+%0d", name, got, done_t.size(), 2 + 9 * bp);
        end
        total++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || cyc - t0 != 3 + 9 * bp) begin
            bad++;
            $display("FAIL %s_ready_again at +%0d ready=%b busy=%b exp +%0d ready=1 busy=0",
                     name, cyc - t0, o_ready, o_busy, 3 + 9 * bp);
        end
    endtask

    task automatic test_reset();
        sel     = 1'b0;
        n_rst   = 1'b1;
        dv      = 1'b1;
        data_in = 8'hFF;
        repeat (3) tick();
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        total++;
        if (o_le !== 1'b0 || o_se !== 1'b0) begin
            bad++;
            $display("FAIL rst_strobes got load=%b shift=%b exp 0 0", o_le, o_se);
        end
        total++;
        if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", o_done); end
        total++;
        if (a_po !== RESET_WORD) begin bad++; $display("FAIL rst_word_a got=%h exp=%h", a_po, RESET_WORD); end
        total++;
        if (b_po !== RESET_WORD || b_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_b got word=%h ready=%b exp word=%h ready=1", b_po, b_ready, RESET_WORD);
        end
        n_rst = 1'b0;
        dv    = 1'b0;
        repeat (2) tick();
        total++;
        if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_po !== RESET_WORD) begin
            bad++;
            $display("FAIL rst_release got busy=%b ready=%b word=%h exp 0 1 %h", o_busy, o_ready, o_po, RESET_WORD);
        end
    endtask

    task automatic test_single_frame();
        int t0;
        sel = 1'b0;
        clear_events();
        launch(8'hA5, exp_word(8'hA5), t0);
        // Mid-frame data_valid with a different byte must be ignored.
        data_in = 8'h5A;
        dv      = 1'b1;
        repeat (40) tick();
        total++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0 || o_po !== exp_word(8'hA5)) begin
            bad++;
            $display("FAIL mid_frame got busy=%b ready=%b word=%h exp 1 0 %h",
                     o_busy, o_ready, o_po, exp_word(8'hA5));
        end
        dv      = 1'b0;
        data_in = 8'h00;
        wait_done(200);
        check_timing("a5_bp10", t0, BP_A);
    endtask

    task automatic test_parity();
        int t0;
        logic [8:0] w07;
        logic [8:0] w03;
`ifdef TX_FRAME_PARITY_EN
        w07 = 9'h00F;
        w03 = 9'h006;
`else
        w07 = 9'h00F;
        w03 = 9'h007;
`endif
        sel = 1'b0;
        clear_events();
        launch(8'h07, w07, t0);
        wait_done(200);
        launch(8'h03, w03, t0);
        wait_done(200);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL parity_pending got %0d words unconsumed exp 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int n;
        sel = 1'b0;
        clear_events();
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", o_ready); end
        data_in = 8'h11;
        dv      = 1'b1;
        sb_q.push_back(exp_word(8'h11));
        t0 = cyc;
        tick();
        data_in = 8'h22;
        sb_q.push_back(exp_word(8'h22));
        n = 0;
        while (le_t.size() < 2 && n < 300) begin
            tick();
            n++;
        end
        dv = 1'b0;
        total++;
        if (le_t.size() != 2 || done_t.size() != 1) begin
            bad++;
            $display("FAIL b2b_events got loads=%0d dones=%0d exp 2 1", le_t.size(), done_t.size());
        end else begin
            total++;
            if (done_t[0] - t0 != 2 + 9 * BP_A) begin
                bad++;
                $display("FAIL b2b_first_done got=+%0d exp=+%0d", done_t[0] - t0, 2 + 9 * BP_A);
            end
            total++;
            if (le_t[1] - done_t[0] != 2) begin
                bad++;
                $display("FAIL b2b_gap got load-after-done=%0d exp=2", le_t[1] - done_t[0]);
            end
        end
        wait_done(200);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_pending got %0d words unconsumed exp 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        sel = 1'b0;
        clear_events();
        launch(8'hC3, exp_word(8'hC3), t0);
        while (cyc < t0 + 40) tick();
        n_rst   = 1'b1;
        dv      = 1'b1;
        data_in = 8'hFF;
        tick();
        total++;
        if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state got busy=%b ready=%b done=%b exp 0 1 0", o_busy, o_ready, o_done);
        end
        total++;
        if (o_po !== RESET_WORD) begin
            bad++;
            $display("FAIL midrst_word got=%h exp=%h", o_po, RESET_WORD);
        end
        n_rst = 1'b0;
        dv    = 1'b0;
        repeat (100) tick();
        total++;
        if (done_t.size() != 0 || le_t.size() != 1 || se_t.size() > 3) begin
            bad++;
            $display("FAIL midrst_abort got dones=%0d loads=%0d shifts=%0d exp 0 1 <=3",
                     done_t.size(), le_t.size(), se_t.size());
        end
        clear_events();
        launch(8'h3C, exp_word(8'h3C), t0);
        wait_done(200);
        check_timing("3c_after_rst", t0, BP_A);
    endtask

    task automatic test_short_period();
        int t0;
        sel = 1'b1;
        repeat (2) tick();
        clear_events();
        launch(8'hA5, exp_word(8'hA5), t0);
        wait_done(100);
        check_timing("a5_bp2", t0, BP_B);
    endtask

    task automatic test_random();
        int t0;
        logic [7:0] b;
        sel = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            clear_events();
            b = 8'($urandom_range(0, 255));
            launch(b, exp_word(b), t0);
            wait_done(100);
            total++;
            if (se_t.size() != 8 || done_t.size() != 1) begin
                bad++;
                $display("FAIL rand[%0d] byte=%h got shifts=%0d dones=%0d exp 8 1",
                         i, b, se_t.size(), done_t.size());
            end
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL rand_pending got %0d words unconsumed exp 0", sb_q.size());
        end
    endtask

    initial begin
        sel     = 1'b0;
        n_rst   = 1'b1;
        dv      = 1'b0;
        data_in = 8'h00;
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_short_period();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
